// File: rtl/combined_wire_pkg.sv
// Shared writeback types: register, jump and CSR write records plus the commit entry
// that bundles one of each for the in-order commit buffer.
package combined_wire;
  typedef logic        bool;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr;

  typedef struct packed {
    logic    reg_write_enable;
    reg_addr reg_dest_addr;
    word_t   reg_write_data;
  } reg_writer;

  typedef struct packed {
    logic  jump_inst;
    logic  do_jump;
    word_t dest_addr;
  } jump_writer;

  typedef struct packed {
    logic [11:0] csr_addr;
    word_t       csr_data;
  } csr_writer;

  typedef struct packed {
    reg_writer  reg_w;
    jump_writer jump_w;
    bool        csr_en;
    csr_writer  csr_w;
  } commit_entry;

  localparam int WB_COMMIT_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/wb_commit_buffer_fwd.sv
// Forwarding lookup for one port: youngest occupied entry writing the requested register wins.
// Only compiled into the buffer when WB_COMMIT_FWD_EN is defined.
module wb_commit_fwd
  import combined_wire::*;
#(
  parameter int DEPTH = WB_COMMIT_DEPTH_DEFAULT
) (
  input  commit_entry                    entries [DEPTH],
  input  logic [$clog2(DEPTH+1)-1:0]     count,
  input  logic [$clog2(DEPTH)-1:0]       head,
  input  reg_addr                        addr,
  output logic                           hit,
  output word_t                          data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Walk oldest to youngest so a younger match overrides an older one.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr != '0) &&
          entries[idx].reg_w.reg_write_enable &&
          (entries[idx].reg_w.reg_dest_addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx].reg_w.reg_write_data;
      end
    end
  end
endmodule

// File: rtl/wb_commit_buffer.sv
// In-order commit buffer: entries retire one per cycle; a retiring taken jump squashes younger
// entries. Define WB_COMMIT_FWD_EN to add the decode forwarding lookup ports.
//
// Handshake: a transfer happens on a clock edge where valid && ready; valid never depends on
// ready, and in_ready/out_valid depend on registered state only.
module wb_commit_buffer
  import combined_wire::*;
#(
  parameter int DEPTH = WB_COMMIT_DEPTH_DEFAULT
`ifdef WB_COMMIT_FWD_EN
  , parameter int NUM_FWD = 2
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  reg_writer                    in_reg,
  input  jump_writer                   in_jump,
  input  bool                          in_csr_en,
  input  csr_writer                    in_csr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output reg_writer                    out_reg,
  output jump_writer                   out_jump,
  output bool                          out_csr_en,
  output csr_writer                    out_csr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [63:0]                  retire_count,
  output logic                         squash
`ifdef WB_COMMIT_FWD_EN
  ,
  input  reg_addr                      fwd_addr [NUM_FWD],
  output logic                         fwd_hit  [NUM_FWD],
  output word_t                        fwd_data [NUM_FWD]
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  commit_entry   mem [DEPTH];
  logic [PW-1:0] head, tail, head_next;
  commit_entry   in_entry, head_entry;
  logic          push, pop, taken, write_en;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head_entry = mem[head];
  assign out_reg    = head_entry.reg_w;
  assign out_jump   = head_entry.jump_w;
  assign out_csr_en = head_entry.csr_en;
  assign out_csr    = head_entry.csr_w;

  assign taken     = pop && head_entry.jump_w.jump_inst && head_entry.jump_w.do_jump;
  // Flush outranks the squash, so no squash pulse is reported under a flush.
  assign squash    = taken && !flush;
  assign head_next = pop ? head + PW'(1) : head;
  assign write_en  = push && !flush && !taken;

  // Writes to x0 are architecturally void, so drop the enable at enqueue.
  always_comb begin
    in_entry        = '{reg_w: in_reg, jump_w: in_jump, csr_en: in_csr_en, csr_w: in_csr};
    in_entry.reg_w.reg_write_enable = in_reg.reg_write_enable && (in_reg.reg_dest_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[tail] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_count <= '0;
    end else begin
      head <= head_next;
      if (pop) retire_count <= retire_count + 64'd1;
      if (flush || taken) begin
        count <= '0;
        tail  <= head_next;
      end else begin
        if (push) tail <= tail + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef WB_COMMIT_FWD_EN
  for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
    wb_commit_fwd #(.DEPTH(DEPTH)) u_fwd (
      .entries (mem),
      .count   (count),
      .head    (head),
      .addr    (fwd_addr[g]),
      .hit     (fwd_hit[g]),
      .data    (fwd_data[g])
    );
  end
`endif
endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer (DEPTH=4); forwarding checks compile in with WB_COMMIT_FWD_EN.
module tb_wb_commit_buffer;
  import combined_wire::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready, out_valid, in_ready, squash;
  reg_writer   in_reg, out_reg;
  jump_writer  in_jump, out_jump;
  bool         in_csr_en, out_csr_en;
  csr_writer   in_csr, out_csr;
  logic [2:0]  count;
  logic [63:0] retire_count;
`ifdef WB_COMMIT_FWD_EN
  reg_addr     fwd_addr [2];
  logic        fwd_hit  [2];
  word_t       fwd_data [2];
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_commit_buffer #(
    .DEPTH(4)
`ifdef WB_COMMIT_FWD_EN
    , .NUM_FWD(2)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_jump(in_jump),
    .in_csr_en(in_csr_en), .in_csr(in_csr),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg), .out_jump(out_jump),
    .out_csr_en(out_csr_en), .out_csr(out_csr),
    .count(count), .retire_count(retire_count), .squash(squash)
`ifdef WB_COMMIT_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] data, input logic [4:0] dest,
                       input logic we, input logic jmp, input logic dj, input logic [31:0] daddr);
    in_valid                = v;
    in_reg.reg_write_enable = we;
    in_reg.reg_dest_addr    = dest;
    in_reg.reg_write_data   = data;
    in_jump.jump_inst       = jmp;
    in_jump.do_jump         = dj;
    in_jump.dest_addr       = daddr;
    in_csr_en               = 1'b0;
    in_csr                  = '0;
  endtask

  task automatic push1(input logic [31:0] data, input logic [4:0] dest);
    drive(1'b1, data, dest, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int cycles, pushed, retired;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef WB_COMMIT_FWD_EN
    fwd_addr[0] = 5'd0; fwd_addr[1] = 5'd0;
`endif
    do_reset();
    settle();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_retire_count", retire_count, 0);
    check("rst_squash", squash, 0);
`ifdef WB_COMMIT_FWD_EN
    check("rst_fwd_hit", fwd_hit[0], 0);
    check("rst_fwd_data", fwd_data[0], 0);
`endif

    // Fill/drain: five pushes offered, only four accepted.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    check("fill_in_ready", in_ready, 0);
    check("fill_count", count, 4);
    tick();
    in_valid = 1'b0;
    check("fill_count_hold", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("drain_valid", out_valid, 1);
      check("drain_data", out_reg.reg_write_data, 64'(i));
      tick();
    end
    check("drain_empty", out_valid, 0);
    check("drain_retire_count", retire_count, 4);

    // Pointer wrap with random out_ready and a scoreboard.
    cycles = 0; pushed = 0; retired = 0;
    while (retired < 10 && cycles < 200) begin
      if (pushed < 10) drive(1'b1, 32'h100 + 32'(pushed), 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
      else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      settle();
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("wrap_underflow", 1, 0);
        else check("wrap_data", out_reg.reg_write_data, exp_q.pop_front());
        retired++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_reg.reg_write_data);
        pushed++;
      end
      check("wrap_count_bound", count <= 3'd4, 1);
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check("wrap_timeout", cycles < 200, 1);
    check("wrap_retire_count", retire_count, 14);

    // Jump squash: A, B (taken jump), C, D.
    do_reset();
    out_ready = 1'b0;
    push1(32'hA, 5'd1);
    drive(1'b1, 32'hB, 5'd2, 1'b1, 1'b1, 1'b1, 32'h8000_0100);
    tick();
    push1(32'hC, 5'd3);
    push1(32'hD, 5'd4);
    out_ready = 1'b1;
    settle();
    check("sq_a_data", out_reg.reg_write_data, 32'hA);
    check("sq_a_squash", squash, 0);
    tick();
    check("sq_b_data", out_reg.reg_write_data, 32'hB);
    check("sq_b_dest", out_jump.dest_addr, 32'h8000_0100);
    check("sq_b_squash", squash, 1);
    tick();
    check("sq_count", count, 0);
    check("sq_out_valid", out_valid, 0);
    check("sq_retire_count", retire_count, 2);
    check("sq_squash_clear", squash, 0);

    // Register 0 and a not-taken jump.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h99, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    in_csr_en = 1'b1;
    in_csr.csr_addr = 12'h300;
    in_csr.csr_data = 32'h55;
    tick();
    drive(1'b1, 32'h77, 5'd3, 1'b1, 1'b1, 1'b0, 32'h4000);
    tick();
    push1(32'h88, 5'd4);
    out_ready = 1'b1;
    settle();
    check("r0_we", out_reg.reg_write_enable, 0);
    check("r0_csr_en", out_csr_en, 1);
    check("r0_csr_data", {out_csr.csr_addr, out_csr.csr_data}, {12'h300, 32'h55});
    tick();
    check("nt_jump_inst", out_jump.jump_inst, 1);
    check("nt_we", out_reg.reg_write_enable, 1);
    check("nt_squash", squash, 0);
    tick();
    check("nt_next_data", out_reg.reg_write_data, 32'h88);
    check("nt_count", count, 1);
    tick();
    check("nt_retire_count", retire_count, 3);

`ifdef WB_COMMIT_FWD_EN
    do_reset();
    out_ready = 1'b0;
    push1(32'h11, 5'd5);
    push1(32'h22, 5'd5);
    fwd_addr[0] = 5'd5;
    fwd_addr[1] = 5'd0;
    settle();
    check("fwd_hit", fwd_hit[0], 1);
    check("fwd_data", fwd_data[0], 32'h22);
    check("fwd_x0_miss", fwd_hit[1], 0);
    out_ready = 1'b1;
    tick();
    tick();
    check("fwd_after_retire", fwd_hit[0], 0);
    out_ready = 1'b0;
`endif

    // Flush with a simultaneous push at count 3.
    do_reset();
    out_ready = 1'b0;
    push1(32'h31, 5'd1);
    push1(32'h32, 5'd1);
    push1(32'h33, 5'd1);
    drive(1'b1, 32'h34, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    settle();
    check("fl_pre_count", count, 3);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_count", count, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    push1(32'h35, 5'd1);
    check("fl_next_data", out_reg.reg_write_data, 32'h35);
    check("fl_next_count", count, 1);
    check("fl_retire_count", retire_count, 0);

    // Reset mid-operation at count 2.
    push1(32'h36, 5'd1);
    check("rm_pre_count", count, 2);
    reset_n = 1'b0;
    out_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    out_ready = 1'b0;
    check("rm_count", count, 0);
    check("rm_out_valid", out_valid, 0);
    check("rm_in_ready", in_ready, 1);
    check("rm_retire_count", retire_count, 0);
    check("rm_squash", squash, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_commit_buffer.md
# wb_commit_buffer

Parametrised in-order commit buffer between the execute/memory stages and architectural state (register file, PC redirect, CSR file). Each entry combines one register write, one jump record and one optional CSR write. Entries retire one per cycle under a valid/ready handshake. A retiring taken jump squashes all younger entries. Optional forwarding ports let decode read not-yet-retired register values.

## Interface
- `DEPTH`, default 4: entry count; a power of two, at least 2.
- `NUM_FWD`, default 2: forwarding lookup ports; only present with `WB_COMMIT_FWD_EN`.
- `clk` in 1: clock. One clock domain only.
- `reset_n` in 1: reset. Synchronous and active-low.
- `flush` in 1: external flush; discards every entry.
- `in_valid` in 1 / `in_ready` out 1: enqueue handshake.
- `in_reg` in `reg_writer`: register write of the incoming entry.
- `in_jump` in `jump_writer`: jump record of the incoming entry.
- `in_csr_en` in `bool`: the incoming entry carries a CSR write.
- `in_csr` in `csr_writer`: CSR write payload.
- `out_valid` out 1 / `out_ready` in 1: retire handshake.
- `out_reg`, `out_jump`, `out_csr_en`, `out_csr` out: head entry fields.
- `count` out `$clog2(DEPTH+1)`: number of occupied entries.
- `retire_count` out 64: total entries retired since reset.
- `squash` out 1: pulses in the cycle a retiring jump discards younger entries.
- `fwd_addr[NUM_FWD]` in `reg_addr`: forwarding lookup address.
- `fwd_hit[NUM_FWD]` out 1: a matching entry was found.
- `fwd_data[NUM_FWD]` out `word_t`: forwarded value.

## Operation
- **Storage:** circular FIFO with `head` and `tail` pointers of width `$clog2(DEPTH)`, wrapping modulo `DEPTH`, plus a separate `count`.
- **Enqueue:**
  - An entry is pushed when `in_valid && in_ready`.
  - `in_ready = (count < DEPTH)`. There is no combinational enqueue-while-full, even when a pop happens in the same cycle.
- **Register-0 rule:** at enqueue, if `in_reg.reg_dest_addr == 0`, the stored `reg_write_enable` is forced to 0.
- **Retire:**
  - The entry is popped when `out_valid && out_ready`.
  - `out_valid = (count != 0)`.
  - The `out_*` signals are driven directly from the head entry.
  - `retire_count` increments by 1 on each pop.
- **Jump squash:**
  - Applies when the popped entry has `jump_inst && do_jump`.
  - All remaining entries are discarded, and any entry pushed in the same cycle is discarded.
  - Resulting state: `count = 0`, `tail = head + 1`, `squash = 1` for that cycle.
  - A jump with `do_jump = 0` retires normally.
- **External flush:**
  - Sets `count = 0` and `tail = head`.
  - Priority: flush over squash over push.
  - A pop in the flush cycle still completes, and `retire_count` still counts it if `out_ready` was high.
- **Simultaneous push and pop (not full):** `count` is unchanged and both pointers advance.
- **Forwarding** (`WB_COMMIT_FWD_EN`), per port:
  - Scan occupied entries from youngest to oldest.
  - The first entry with `reg_write_enable` and `reg_dest_addr == fwd_addr` sets `fwd_hit = 1` and `fwd_data = reg_write_data`.
  - `fwd_addr == 0` always gives a miss.
  - The head entry is included even in the cycle it retires.
  - Purely combinational.

## Timing
- **Reset** (`reset_n` low at a clock edge):
  - `head = tail = 0`, `count = 0`, `out_valid = 0`, `in_ready = 1`.
  - `retire_count = 0`, `squash = 0`, all `fwd_hit = 0`, all `fwd_data = 0`.
  - Reset mid-operation discards all entries without retiring them.
- **Latency:** an entry pushed at edge N is visible on `out_*` at cycle N+1, so minimum enqueue-to-retire is 1 cycle. There is no bypass when empty.
- **Throughput:** 1 push and 1 pop per cycle.
- **Combinational paths:**
  - `in_ready`, `out_valid` and `count` are functions of registered state only.
  - `squash` depends combinationally on `out_ready`.
  - `fwd_*` depend combinationally on `fwd_addr` and state.

## Configuration
- `WB_COMMIT_FWD_EN` defined:
  - The `fwd_addr`, `fwd_hit` and `fwd_data` ports and the `wb_commit_fwd` instance are compiled in.
- Not defined:
  - Those ports and the lookup logic are absent.
  - Consumers must interlock on `count != 0` or on their own scoreboard.
  - All other behaviour is identical.

## Structure
- Package `combined_wire` gains `typedef struct packed { reg_writer reg_w; jump_writer jump_w; bool csr_en; csr_writer csr_w; } commit_entry;`.
- `WB_COMMIT_DEPTH_DEFAULT = 4` also goes in `combined_wire`.
- Sub-module `wb_commit_fwd`:
  - Inputs: the entry array, occupancy, `head` and one address.
  - Outputs: hit and data.
  - Instantiated `NUM_FWD` times.
- The top level holds the storage, pointers, counters and squash/flush control.

## Test plan
- **Fill/drain:** with `DEPTH = 4` and `out_ready = 0`, push 5 entries.
  - `in_ready` drops after the 4th and `count = 4`.
  - Raising `out_ready` retires data 1, 2, 3, 4 in order and `retire_count = 4`.
- **Pointer wrap:** push/pop 10 entries with random `out_ready`.
  - Order is preserved across pointer wrap and `count` never exceeds 4.
- **Jump squash:** enqueue A, B(`jump_inst = 1`, `do_jump = 1`, `dest_addr = 0x8000_0100`), C, D, then retire.
  - A and B retire, `squash` pulses with B, and C and D never appear.
  - `count = 0` and `retire_count = 2`.
- **Register 0 and not-taken jump:**
  - A push with `reg_dest_addr = 0`, `reg_write_enable = 1` retires with `reg_write_enable = 0`.
  - A jump with `do_jump = 0` causes no squash.
- **Forwarding:** enqueue x5 = 0x11, then x5 = 0x22, and look up x5 with `fwd_addr = 5`.
  - Expect `fwd_hit = 1` and `fwd_data = 0x22`.
  - After both retire, `fwd_hit = 0`.
  - `fwd_addr = 0` misses.
- **Flush and reset:**
  - `flush` together with a push at `count = 3` gives `count = 0`, and the pushed entry is lost.
  - `reset_n = 0` at `count = 2` gives all reset values on the next cycle.
